// File: rtl/vga_rect_drawer.sv
// Rectangle pixel generator feeding vga_adapter: walks a clipped rectangle in
// raster order and emits one pixel per clock, filled or as a 1-pixel outline.
module vga_rect_drawer #(
    parameter RESOLUTION = "640x480",
    parameter int COLOR_DEPTH = 9,
    localparam int nX = (RESOLUTION == "320x240") ? 9 :
                        (RESOLUTION == "160x120") ? 8 : 10,
    localparam int nY = nX - 1,
    localparam int XMAX = (nX == 10) ? 639 : (nX == 9) ? 319 : 159,
    localparam int YMAX = (nX == 10) ? 479 : (nX == 9) ? 239 : 119
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   start,
    input  logic [nX-1:0]          x0,
    input  logic [nY-1:0]          y0,
    input  logic [nX:0]            w,
    input  logic [nY:0]            h,
    input  logic [COLOR_DEPTH-1:0] color_in,
    input  logic                   mode,
    output logic [nX-1:0]          x,
    output logic [nY-1:0]          y,
    output logic [COLOR_DEPTH-1:0] color,
    output logic                   write,
    output logic                   busy,
    output logic                   done
);

    // End coordinates carry two extra bits so x0 + w - 1 can never wrap.
    localparam int XW = nX + 2;
    localparam int YW = nY + 2;

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, FINISH} state_t;
    state_t state;

    logic [nX-1:0]          x0_reg;
    logic [nY-1:0]          y0_reg;
    logic [nX:0]            w_reg;
    logic [nY:0]            h_reg;
    logic [COLOR_DEPTH-1:0] color_reg;
    logic                   mode_reg;

    logic [XW-1:0] ex, cx1;
    logic [YW-1:0] ey, cy1;
    logic          empty, last_col, last_row;
    logic [nX-1:0] x_next;
    logic [nY-1:0] y_next;
    logic          write_next;

    assign ex  = XW'(x0_reg) + XW'(w_reg) - XW'(1);
    assign ey  = YW'(y0_reg) + YW'(h_reg) - YW'(1);
    assign cx1 = (ex > XW'(XMAX)) ? XW'(XMAX) : ex;
    assign cy1 = (ey > YW'(YMAX)) ? YW'(YMAX) : ey;

    assign empty = (w_reg == '0) || (h_reg == '0) ||
                   (XW'(x0_reg) > XW'(XMAX)) || (YW'(y0_reg) > YW'(YMAX));

    // x/y double as the cursor: they always hold the pixel being presented.
    assign last_col = (XW'(x) == cx1);
    assign last_row = (YW'(y) == cy1);
    assign x_next   = last_col ? x0_reg : x + nX'(1);
    assign y_next   = last_col ? y + nY'(1) : y;

    // Edges are tested against the unclipped ends so clipped sides stay open.
    assign write_next = !mode_reg ||
                        (x_next == x0_reg) || (XW'(x_next) == ex) ||
                        (y_next == y0_reg) || (YW'(y_next) == ey);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            color     <= '0;
            write     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            x0_reg    <= '0;
            y0_reg    <= '0;
            w_reg     <= '0;
            h_reg     <= '0;
            color_reg <= '0;
            mode_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    write <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        x0_reg    <= x0;
                        y0_reg    <= y0;
                        w_reg     <= w;
                        h_reg     <= h;
                        color_reg <= color_in;
                        mode_reg  <= mode;
                        busy      <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (empty) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        // The origin is a corner, so it is written in both modes.
                        x     <= x0_reg;
                        y     <= y0_reg;
                        color <= color_reg;
                        write <= 1'b1;
                        state <= DRAW;
                    end
                end
                DRAW: begin
                    if (last_col && last_row) begin
                        write <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        x     <= x_next;
                        y     <= y_next;
                        write <= write_next;
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_rect_drawer.sv
// Scoreboard bench for vga_rect_drawer at 160x120: expected pixels are queued
// when a command is issued and popped as the DUT writes them.
module tb_vga_rect_drawer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [8:0] w;
    logic [7:0] h;
    logic [8:0] color_in;
    logic       mode;
    logic [7:0] x;
    logic [6:0] y;
    logic [8:0] color;
    logic       write;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    logic [23:0] exp_q[$];

    vga_rect_drawer #(.RESOLUTION("160x120"), .COLOR_DEPTH(9)) dut (
        .CLOCK_50(clk), .reset(reset), .start(start),
        .x0(x0), .y0(y0), .w(w), .h(h), .color_in(color_in), .mode(mode),
        .x(x), .y(y), .color(color), .write(write), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference model: pushes expected writes, returns pixel count and DRAW cycles.
    task automatic model(input int px0, py0, pw, ph, input logic [8:0] col, input logic md,
                         output int n_pix, output int n_cyc);
        int ex, ey, cx1, cy1;
        n_pix = 0;
        n_cyc = 0;
        if (pw == 0 || ph == 0 || px0 > 159 || py0 > 119) return;
        ex  = px0 + pw - 1;
        ey  = py0 + ph - 1;
        cx1 = (ex > 159) ? 159 : ex;
        cy1 = (ey > 119) ? 119 : ey;
        for (int yy = py0; yy <= cy1; yy++)
            for (int xx = px0; xx <= cx1; xx++) begin
                n_cyc++;
                if (!md || xx == px0 || xx == ex || yy == py0 || yy == ey) begin
                    exp_q.push_back({8'(xx), 7'(yy), col});
                    n_pix++;
                end
            end
    endtask

    always @(negedge clk) begin
        if (write) begin
            logic [23:0] e;
            wr_count++;
            chk("unexpected_write", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pixel_xyc", {x, y, color}, e);
                $display("pixel x=%0d y=%0d color=%03h", x, y, color);
            end
        end
    end

    task automatic run_cmd(input int px0, py0, pw, ph, input logic [8:0] col,
                           input logic md, input bit keep);
        int n_pix, n_cyc, exp_done, first_k, done_k, busy_n, wr0;
        model(px0, py0, pw, ph, col, md, n_pix, n_cyc);
        exp_done = n_cyc + 2;
        @(negedge clk);
        x0 = 8'(px0); y0 = 7'(py0); w = 9'(pw); h = 8'(ph);
        color_in = col; mode = md; start = 1'b1;
        wr0 = wr_count;
        first_k = -1; done_k = -1; busy_n = 0;
        for (int k = 1; k <= 500 && done_k < 0; k++) begin
            @(negedge clk);
            if (keep) begin
                x0 = 8'(k * 37); y0 = 7'(k * 11); w = 9'(k); h = 8'(k + 1);
                color_in = ~col; mode = ~md;
            end else begin
                start = 1'b0;
            end
            if (write && first_k < 0) first_k = k;
            if (busy) busy_n++;
            if (done) done_k = k;
        end
        start = 1'b0;
        chk("done_cycle", done_k, exp_done);
        chk("busy_cycles", busy_n, exp_done - 1);
        chk("first_write", first_k, (n_cyc == 0) ? -1 : 2);
        chk("write_count", wr_count - wr0, n_pix);
        chk("queue_empty", exp_q.size(), 0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        @(negedge clk);
        chk("idle_after", busy, 0);
        $display("cmd x0=%0d y0=%0d w=%0d h=%0d mode=%0d pixels=%0d done_at=%0d",
                 px0, py0, pw, ph, md, wr_count - wr0, done_k);
    endtask

    initial begin
        int n_pix, n_cyc, done_seen;
        reset = 1'b1; start = 1'b0;
        x0 = '0; y0 = '0; w = '0; h = '0; color_in = '0; mode = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_color", color, 0);
        chk("rst_write", write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        @(negedge clk);

        run_cmd(10, 20, 3, 2, 9'h1C0, 1'b0, 1'b0);   // filled 3x2
        run_cmd(0, 0, 4, 4, 9'h03F, 1'b1, 1'b0);     // outline 4x4, hollow centre
        run_cmd(158, 118, 5, 5, 9'h0AA, 1'b0, 1'b0); // clipped at both edges
        run_cmd(150, 115, 20, 10, 9'h155, 1'b1, 1'b0); // clipped outline, open sides
        run_cmd(5, 5, 0, 3, 9'h111, 1'b0, 1'b0);     // empty: w = 0
        run_cmd(200, 5, 3, 3, 9'h111, 1'b0, 1'b0);   // empty: x0 off screen
        run_cmd(30, 40, 1, 4, 9'h0F0, 1'b1, 1'b0);   // w = 1 outline equals filled
        run_cmd(60, 60, 3, 3, 9'h1FF, 1'b0, 1'b1);   // start held, inputs scrambled
        run_cmd(70, 70, 2, 2, 9'h00F, 1'b0, 1'b0);   // follow-up accepted normally

        // Reset during the third pixel of a filled 3x3.
        model(50, 50, 3, 1, 9'h123, 1'b0, n_pix, n_cyc);
        @(negedge clk);
        x0 = 8'd50; y0 = 7'd50; w = 9'd3; h = 8'd3; color_in = 9'h123; mode = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("third_pixel_write", write, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_write", write, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        chk("no_done_after_abort", done_seen, 0);
        chk("abort_queue_empty", exp_q.size(), 0);
        $display("reset abort checked");

        run_cmd(100, 10, 3, 3, 9'h0C3, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
